// File: rtl/mux_2to1_arb.sv
// Registered 2:1 arbitrating multiplexer with valid/ready handshakes on both sources and the sink.
// Define MUX_2TO1_ARB_RR_EN for round-robin contention; the default build uses fixed priority to A.
module mux_2to1_arb #(
   parameter int unsigned width = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] a,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [width-1:0] b,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [width-1:0] c,
   output logic             c_valid,
   input  logic             c_ready,
   output logic             sel
);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_B    = 2'd2
   } grant_e;

   logic [width-1:0] c_q, c_d;
   logic             c_valid_q, c_valid_d;
   logic             sel_q, sel_d;
   logic             last_grant_q, last_grant_d;

   grant_e grant;
   logic   load;
   logic   accept_a;
   logic   accept_b;

   assign load = !c_valid_q || c_ready;

   always_comb begin
      grant = GNT_NONE;
      unique case ({a_valid, b_valid})
         2'b10:   grant = GNT_A;
         2'b01:   grant = GNT_B;
`ifdef MUX_2TO1_ARB_RR_EN
         2'b11:   grant = last_grant_q ? GNT_A : GNT_B;
`else
         2'b11:   grant = GNT_A;
`endif
         default: grant = GNT_NONE;
      endcase
   end

   // Ready is gated by rst_n so neither source sees a handshake while reset is held.
   assign a_ready  = rst_n && load && (grant == GNT_A);
   assign b_ready  = rst_n && load && (grant == GNT_B);
   assign accept_a = a_ready && a_valid;
   assign accept_b = b_ready && b_valid;

   always_comb begin
      c_d          = c_q;
      sel_d        = sel_q;
      c_valid_d    = c_valid_q;
      last_grant_d = last_grant_q;
      if (accept_a) begin
         c_d          = a;
         sel_d        = 1'b0;
         c_valid_d    = 1'b1;
         last_grant_d = 1'b0;
      end else if (accept_b) begin
         c_d          = b;
         sel_d        = 1'b1;
         c_valid_d    = 1'b1;
         last_grant_d = 1'b1;
      end else if (c_ready) begin
         c_valid_d    = 1'b0;
      end
   end

   // last_grant resets to B so the first contention after reset goes to A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q          <= '0;
         sel_q        <= 1'b0;
         c_valid_q    <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         c_q          <= c_d;
         sel_q        <= sel_d;
         c_valid_q    <= c_valid_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign c       = c_q;
   assign c_valid = c_valid_q;
   assign sel     = sel_q;

endmodule

// File: tb/tb_mux_2to1_arb.sv
// Self-checking bench for mux_2to1_arb: directed table, hand-written corner sequences and
// randomized traffic checked against a transaction-level model of the arbiter.
module tb_mux_2to1_arb;

   localparam int unsigned W = 2;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a, b, c;
   logic         a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, sel;

   int total = 0;
   int bad   = 0;

   mux_2to1_arb #(.width(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .b       (b),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .c       (c),
      .c_valid (c_valid),
      .c_ready (c_ready),
      .sel     (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: one output slot (empty or holding data from a source) and the last source served.
   bit           m_full;
   logic [W-1:0] m_data;
   bit           m_src;
   bit           m_last;

   function automatic int pick(input bit av, input bit bv);
      if (av && bv) begin
`ifdef MUX_2TO1_ARB_RR_EN
         return m_last ? 0 : 1;
`else
         return 0;
`endif
      end
      if (av) return 0;
      if (bv) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 0;
      m_data = '0;
      m_src  = 0;
      m_last = 1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of traffic: drive at negedge, check readiness mid-cycle, check registers after posedge.
   task automatic step(input bit av, input logic [W-1:0] ad, input bit bv, input logic [W-1:0] bd,
                       input bit cr, output logic ar_o, output logic br_o);
      int winner;
      @(negedge clk);
      a_valid = av; a = ad; b_valid = bv; b = bd; c_ready = cr;
      #1;
      winner = (m_full && !cr) ? -1 : pick(av, bv);
      check("model a_ready", {31'd0, a_ready}, {31'd0, winner == 0});
      check("model b_ready", {31'd0, b_ready}, {31'd0, winner == 1});
      check("ready exclusive", {31'd0, a_ready && b_ready}, 32'd0);
      ar_o = a_ready;
      br_o = b_ready;
      @(posedge clk);
      if (winner >= 0) begin
         m_full = 1;
         m_data = (winner == 1) ? bd : ad;
         m_src  = (winner == 1);
         m_last = (winner == 1);
      end else if (cr) begin
         m_full = 0;
      end
      #1;
      check("model c_valid", {31'd0, c_valid}, {31'd0, m_full});
      check("model c", {30'd0, c}, {30'd0, m_data});
      check("model sel", {31'd0, sel}, {31'd0, m_src});
   endtask

   task automatic do_reset();
      rst_n = 0; a_valid = 0; b_valid = 0; c_ready = 0; a = '0; b = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst c_valid", {31'd0, c_valid}, 32'd0);
      check("rst c", {30'd0, c}, 32'd0);
      check("rst sel", {31'd0, sel}, 32'd0);
      rst_n = 1;
      model_reset();
   endtask

   // Reset pulled low between edges with sources still valid; outputs must clear without an edge.
   task automatic async_reset();
      @(negedge clk);
      a_valid = 1; b_valid = 1; a = 2'b01; b = 2'b10; c_ready = 1;
      #2 rst_n = 0;
      #1;
      check("async c_valid", {31'd0, c_valid}, 32'd0);
      check("async c", {30'd0, c}, 32'd0);
      check("async sel", {31'd0, sel}, 32'd0);
      check("async a_ready", {31'd0, a_ready}, 32'd0);
      check("async b_ready", {31'd0, b_ready}, 32'd0);
      a_valid = 0; b_valid = 0; c_ready = 0;
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   typedef struct {
      bit           av;
      logic [W-1:0] ad;
      bit           bv;
      logic [W-1:0] bd;
      bit           cr;
      bit           ear;
      bit           ebr;
      logic [W-1:0] ec;
      bit           ecv;
      bit           esel;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic ar, br;

      vecs[0] = '{1, 2'b01, 0, 2'b00, 1,  1, 0, 2'b01, 1, 0};
      vecs[1] = '{0, 2'b00, 1, 2'b00, 0,  0, 0, 2'b01, 1, 0};
      vecs[2] = '{1, 2'b11, 1, 2'b10, 0,  0, 0, 2'b01, 1, 0};
      vecs[3] = '{1, 2'b11, 1, 2'b10, 0,  0, 0, 2'b01, 1, 0};
      vecs[4] = '{0, 2'b11, 1, 2'b00, 1,  0, 1, 2'b00, 1, 1};
      vecs[5] = '{0, 2'b11, 0, 2'b10, 1,  0, 0, 2'b00, 0, 1};
      vecs[6] = '{0, 2'b11, 0, 2'b10, 0,  0, 0, 2'b00, 0, 1};
      vecs[7] = '{1, 2'b10, 0, 2'b01, 0,  1, 0, 2'b10, 1, 0};
      vecs[8] = '{0, 2'b01, 1, 2'b11, 1,  0, 1, 2'b11, 1, 1};
      vecs[9] = '{0, 2'b01, 0, 2'b11, 0,  0, 0, 2'b11, 1, 1};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].cr, ar, br);
         check($sformatf("vec%0d a_ready", i), {31'd0, ar}, {31'd0, vecs[i].ear});
         check($sformatf("vec%0d b_ready", i), {31'd0, br}, {31'd0, vecs[i].ebr});
         check($sformatf("vec%0d c", i), {30'd0, c}, {30'd0, vecs[i].ec});
         check($sformatf("vec%0d c_valid", i), {31'd0, c_valid}, {31'd0, vecs[i].ecv});
         check($sformatf("vec%0d sel", i), {31'd0, sel}, {31'd0, vecs[i].esel});
      end

      // Mid-transfer reset while c holds B data (sel=1).
      async_reset();

      // Both sources held valid after reset: first contention goes to A in either configuration.
      for (int i = 0; i < 4; i++) begin
         step(1, 2'b10, 1, 2'b11, 1, ar, br);
`ifdef MUX_2TO1_ARB_RR_EN
         check("rr c", {30'd0, c}, (i % 2 == 0) ? 32'h2 : 32'h3);
         check("rr sel", {31'd0, sel}, (i % 2 == 0) ? 32'd0 : 32'd1);
         check("rr b_ready", {31'd0, br}, (i % 2 == 0) ? 32'd0 : 32'd1);
`else
         check("fp c", {30'd0, c}, 32'h2);
         check("fp sel", {31'd0, sel}, 32'd0);
         check("fp b_ready", {31'd0, br}, 32'd0);
`endif
      end

      // Last accepted is A before reset; reset must restore A-first contention.
      step(1, 2'b01, 0, 2'b00, 1, ar, br);
      check("pre-rst sel", {31'd0, sel}, 32'd0);
      async_reset();
      step(1, 2'b01, 1, 2'b10, 1, ar, br);
      check("post-rst winner a_ready", {31'd0, ar}, 32'd1);
      check("post-rst winner c", {30'd0, c}, 32'h1);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
         end else begin
            step($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 1) == 1, W'($urandom),
                 $urandom_range(0, 3) != 0, ar, br);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
